usb_nrzi_tx_encoder: RTL and testbench

USB_NRZI_TX_ENCODER -- requirements
Module: usb_nrzi_tx_encoder

---
 rtl/usb_tx_pkg.sv | 36 +++
 rtl/usb_tx_bit_timer.sv | 29 ++
 rtl/usb_nrzi_tx_encoder.sv | 173 +++++++++++++++++
 tb/tb_usb_nrzi_tx_encoder.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/usb_tx_pkg.sv
// Shared types for the USB NRZI transmit path: FSM state encoding and D+/D- line states.
package usb_tx_pkg;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_SEND    = 3'd1;
   localparam logic [2:0] S_STUFF   = 3'd2;
   localparam logic [2:0] S_EOP_SE0 = 3'd3;
   localparam logic [2:0] S_EOP_J   = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE    = S_IDLE,
      ST_SEND    = S_SEND,
      ST_STUFF   = S_STUFF,
      ST_EOP_SE0 = S_EOP_SE0,
      ST_EOP_J   = S_EOP_J
   } tx_state_e;

   typedef struct packed {
      logic dp;
      logic dm;
   } line_t;

   localparam line_t LINE_J   = 2'b10;
   localparam line_t LINE_K   = 2'b01;
   localparam line_t LINE_SE0 = 2'b00;

   function automatic line_t nrzi_toggle(input line_t level);
      return (level == LINE_J) ? LINE_K : LINE_J;
   endfunction

   // NRZI: a 0 toggles the line, a 1 holds it.
   function automatic line_t nrzi_encode(input line_t level, input logic data);
      return data ? level : nrzi_toggle(level);
   endfunction

endpackage

// File: rtl/usb_tx_bit_timer.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while running, flags the last cycle of a period.
module usb_tx_bit_timer #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic n_rst,
   input  logic run,
   input  logic restart,
   output logic boundary
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt;

   assign boundary = (cnt == CNT_LAST);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         cnt <= '0;
      end else if (!run || restart || boundary) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/usb_nrzi_tx_encoder.sv
// USB NRZI transmit encoder with EOP generation; bit stuffing is built only when
// USB_TX_BITSTUFF_EN is defined.
module usb_nrzi_tx_encoder
   import usb_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 4,
   parameter int STUFF_LEN    = 6,
   parameter int EOP_SE0_BITS = 2
) (
   input  logic clk,
   input  logic n_rst,
   input  logic bit_valid,
   input  logic bit_data,
   input  logic bit_last,
   input  logic abort,
   output logic bit_ready,
   output logic busy,
   output logic underrun,
   output logic d_plus,
   output logic d_minus
);

   // Handshake: a bit moves when bit_valid & bit_ready are both high at a rising clk edge.
   // bit_ready is high throughout IDLE and otherwise only on the last cycle of a bit period
   // that is followed by a fresh data bit; upstream must hold bit_data/bit_last stable
   // while bit_valid is high and unaccepted.
   tx_state_e  state, state_nxt;
   line_t      level, level_nxt;
   line_t      line_q, line_nxt;
   logic       cur_last, cur_last_nxt;
   logic [1:0] eop_cnt, eop_nxt;
   logic       underrun_nxt;
   logic       boundary, run, handshake, abort_take, take_bit, stuff_due;

   usb_tx_bit_timer #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_bit_timer (
      .clk      (clk),
      .n_rst    (n_rst),
      .run      (run),
      .restart  (abort_take),
      .boundary (boundary)
   );

`ifdef USB_TX_BITSTUFF_EN
   logic [3:0] ones, ones_nxt;

   assign stuff_due = (ones == 4'(STUFF_LEN));

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         ones <= '0;
      end else begin
         ones <= ones_nxt;
      end
   end

   always_comb begin
      ones_nxt = ones;
      if (take_bit) begin
         ones_nxt = bit_data ? ones + 4'd1 : 4'd0;
      end else if (state == ST_SEND && boundary && stuff_due && !abort_take) begin
         ones_nxt = 4'd0;
      end else if (state == ST_EOP_J && boundary) begin
         ones_nxt = 4'd0;
      end
   end
`else
   // No run-length tracking without stuffing; STUFF_LEN only has to be in range.
   localparam bit STUFF_LEN_OK = (STUFF_LEN >= 2) && (STUFF_LEN <= 15);
   assign stuff_due = 1'b0 & STUFF_LEN_OK;
`endif

   assign run        = (state != ST_IDLE);
   assign busy       = (state != ST_IDLE);
   assign handshake  = bit_valid & bit_ready;
   assign abort_take = abort & ((state == ST_SEND) || (state == ST_STUFF));
   assign take_bit   = handshake & ~abort_take;
   assign d_plus     = line_q.dp;
   assign d_minus    = line_q.dm;

   // After a stuff bit the next data bit is fetched on the stuff period's last cycle.
   always_comb begin
      case (state)
         ST_IDLE:  bit_ready = 1'b1;
         ST_SEND:  bit_ready = boundary & ~stuff_due & ~cur_last;
         ST_STUFF: bit_ready = boundary & ~cur_last;
         default:  bit_ready = 1'b0;
      endcase
   end

   always_comb begin
      state_nxt    = state;
      level_nxt    = level;
      line_nxt     = line_q;
      cur_last_nxt = cur_last;
      eop_nxt      = eop_cnt;
      underrun_nxt = 1'b0;
      case (state)
         ST_IDLE: begin
            if (handshake) begin
               state_nxt = ST_SEND;
            end
         end
         ST_SEND, ST_STUFF: begin
            if (abort_take) begin
               state_nxt = ST_EOP_SE0;
               line_nxt  = LINE_SE0;
               eop_nxt   = 2'd0;
            end else if (boundary) begin
               if (state == ST_SEND && stuff_due) begin
                  state_nxt = ST_STUFF;
                  level_nxt = nrzi_toggle(level);
                  line_nxt  = nrzi_toggle(level);
               end else if (cur_last || !bit_valid) begin
                  state_nxt    = ST_EOP_SE0;
                  line_nxt     = LINE_SE0;
                  eop_nxt      = 2'd0;
                  underrun_nxt = ~cur_last;
               end else begin
                  state_nxt = ST_SEND;
               end
            end
         end
         ST_EOP_SE0: begin
            if (boundary) begin
               if (eop_cnt == 2'(EOP_SE0_BITS - 1)) begin
                  state_nxt = ST_EOP_J;
                  line_nxt  = LINE_J;
               end else begin
                  eop_nxt = eop_cnt + 2'd1;
               end
            end
         end
         ST_EOP_J: begin
            if (boundary) begin
               state_nxt = ST_IDLE;
               level_nxt = LINE_J;
               line_nxt  = LINE_J;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            level_nxt = LINE_J;
            line_nxt  = LINE_J;
         end
      endcase
      if (take_bit) begin
         level_nxt    = nrzi_encode(level, bit_data);
         line_nxt     = nrzi_encode(level, bit_data);
         cur_last_nxt = bit_last;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state    <= ST_IDLE;
         level    <= LINE_J;
         line_q   <= LINE_J;
         cur_last <= 1'b0;
         eop_cnt  <= 2'd0;
         underrun <= 1'b0;
      end else begin
         state    <= state_nxt;
         level    <= level_nxt;
         line_q   <= line_nxt;
         cur_last <= cur_last_nxt;
         eop_cnt  <= eop_nxt;
         underrun <= underrun_nxt;
      end
   end

endmodule

// File: tb/tb_usb_nrzi_tx_encoder.sv
// Bench for usb_nrzi_tx_encoder: directed packets plus randomized packets checked cycle by
// cycle against a period-level line model; follows USB_TX_BITSTUFF_EN like the design.
module tb_usb_nrzi_tx_encoder;

   localparam int C = 4;
   localparam int S = 6;
   localparam int E = 2;
`ifdef USB_TX_BITSTUFF_EN
   localparam bit STUFF_ON = 1'b1;
`else
   localparam bit STUFF_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic n_rst = 1'b0;
   logic bit_valid = 1'b0;
   logic bit_data = 1'b0;
   logic bit_last = 1'b0;
   logic abort = 1'b0;
   logic bit_ready, busy, underrun, d_plus, d_minus;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   usb_nrzi_tx_encoder #(
      .CLKS_PER_BIT(C),
      .STUFF_LEN(S),
      .EOP_SE0_BITS(E)
   ) dut (
      .clk       (clk),
      .n_rst     (n_rst),
      .bit_valid (bit_valid),
      .bit_data  (bit_data),
      .bit_last  (bit_last),
      .abort     (abort),
      .bit_ready (bit_ready),
      .busy      (busy),
      .underrun  (underrun),
      .d_plus    (d_plus),
      .d_minus   (d_minus)
   );

   // ---------------- scoreboard ----------------
   int checks = 0;
   int failures = 0;
   logic [4:0] exp_q[$];   // per cycle: {d_plus, d_minus, bit_ready, underrun, busy}
   bit pkt[64];
   int model_np;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      if (obs !== expv) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, expv, $time);
      end
   endtask

   // Expected cycles from the first line cycle after the opening handshake to the first idle cycle.
   task automatic build_exp(input int n, input int drop_at, input int abort_at);
      logic [1:0] lvl;
      logic [1:0] per_line[$];
      bit         per_data[$];
      logic [4:0] cyc[$];
      int         ones;
      int         nsend;
      bit         und_case;
      bit         rdy;
      lvl = 2'b10;
      ones = 0;
      und_case = (drop_at >= 0);
      nsend = und_case ? drop_at : n;
      for (int i = 0; i < nsend; i++) begin
         if (!pkt[i]) lvl = ~lvl;
         ones = pkt[i] ? ones + 1 : 0;
         per_line.push_back(lvl);
         per_data.push_back(1'b1);
         if (STUFF_ON && ones == S) begin
            lvl = ~lvl;
            ones = 0;
            per_line.push_back(lvl);
            per_data.push_back(1'b0);
         end
      end
      model_np = per_line.size();
      for (int k = 0; k < per_line.size(); k++) begin
         for (int c = 0; c < C; c++) begin
            rdy = (c == C - 1) &&
                  ((k + 1 < per_line.size() && per_data[k + 1]) || (und_case && k == per_line.size() - 1));
            cyc.push_back({per_line[k], rdy, 1'b0, 1'b1});
         end
      end
      if (abort_at >= 0) begin
         while (cyc.size() > abort_at + 1) void'(cyc.pop_back());
      end
      for (int e = 0; e < C * E; e++) cyc.push_back({2'b00, 1'b0, (und_case && e == 0), 1'b1});
      for (int j = 0; j < C; j++) cyc.push_back({2'b10, 1'b0, 1'b0, 1'b1});
      cyc.push_back({2'b10, 1'b1, 1'b0, 1'b0});
      exp_q = cyc;
   endtask

   // ---------------- driver tasks ----------------
   task automatic run_packet(input string name, input int n, input int drop_at, input int abort_at);
      int idx;
      int lim;
      int cyc;
      logic [4:0] e;
      build_exp(n, drop_at, abort_at);
      lim = (drop_at >= 0) ? drop_at : n;
      @(negedge clk);
      check({name, "/idle_busy"}, busy, 1'b0);
      bit_valid = 1'b1;
      bit_data  = pkt[0];
      bit_last  = (n == 1);
      abort     = 1'b0;
      idx = bit_ready ? 1 : 0;
      cyc = 0;
      while (exp_q.size() > 0) begin
         @(negedge clk);
         e = exp_q.pop_front();
         check({name, "/line"}, {d_plus, d_minus}, e[4:3]);
         check({name, "/rdy"}, bit_ready, e[2]);
         check({name, "/und"}, underrun, e[1]);
         check({name, "/busy"}, busy, e[0]);
         if (idx < lim) begin
            bit_valid = 1'b1;
            bit_data  = pkt[idx];
            bit_last  = (idx == n - 1);
         end else begin
            bit_valid = 1'b0;
            bit_data  = 1'b0;
            bit_last  = 1'b0;
         end
         abort = (cyc == abort_at);
         if (bit_valid && bit_ready) idx++;
         cyc++;
      end
      bit_valid = 1'b0;
      bit_last  = 1'b0;
      abort     = 1'b0;
   endtask

   task automatic abort_in_idle();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         abort = 1'b1;
         bit_valid = 1'b0;
         @(negedge clk);
         check("idle_abort/busy", busy, 1'b0);
         check("idle_abort/line", {d_plus, d_minus}, 2'b10);
      end
      abort = 1'b0;
   endtask

   task automatic reset_mid_packet();
      @(negedge clk);
      bit_valid = 1'b1;
      bit_data  = 1'b0;
      bit_last  = 1'b0;
      repeat (7) @(negedge clk);
      check("rst_mid/busy_before", busy, 1'b1);
      #2 n_rst = 1'b0;
      #1;
      check("rst_mid/line", {d_plus, d_minus}, 2'b10);
      check("rst_mid/busy", busy, 1'b0);
      check("rst_mid/rdy", bit_ready, 1'b1);
      check("rst_mid/und", underrun, 1'b0);
      bit_valid = 1'b0;
      @(negedge clk);
      n_rst = 1'b1;
      @(negedge clk);
      check("rst_mid/line_after", {d_plus, d_minus}, 2'b10);
      check("rst_mid/busy_after", busy, 1'b0);
   endtask

   // ---------------- stimulus + final report ----------------
   initial begin
      #12;
      check("reset/line", {d_plus, d_minus}, 2'b10);
      check("reset/rdy", bit_ready, 1'b1);
      check("reset/busy", busy, 1'b0);
      check("reset/und", underrun, 1'b0);
      @(negedge clk);
      n_rst = 1'b1;

      pkt[0] = 0; pkt[1] = 0; pkt[2] = 1; pkt[3] = 0;
      run_packet("kjjk", 4, -1, -1);

      for (int i = 0; i < 8; i++) pkt[i] = 1;
      run_packet("eight_ones", 8, -1, -1);

      for (int i = 0; i < 6; i++) pkt[i] = 1;
      run_packet("six_ones_last", 6, -1, -1);

      pkt[0] = 1; pkt[1] = 0; pkt[2] = 1; pkt[3] = 0; pkt[4] = 1;
      run_packet("underrun3", 5, 3, -1);

      for (int i = 0; i < 6; i++) pkt[i] = 0;
      run_packet("abort_mid", 6, -1, 2 * C + 1);
      run_packet("abort_hs", 6, -1, 2 * C - 1);

      abort_in_idle();
      reset_mid_packet();

      for (int t = 0; t < 24; t++) begin
         int n;
         int mode;
         int drop;
         int ab;
         n = $urandom_range(1, 20);
         for (int i = 0; i < n; i++) pkt[i] = ($urandom_range(0, 3) != 0);
         mode = $urandom_range(0, 3);
         drop = -1;
         ab = -1;
         if (mode == 2 && n >= 2) drop = $urandom_range(1, n - 1);
         if (mode == 3) begin
            build_exp(n, -1, -1);
            ab = $urandom_range(0, model_np * C - 1);
         end
         run_packet($sformatf("rnd%0d", t), n, drop, ab);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
